adder_accumulator_8bit: RTL
===========================

Name: adder_accumulator_8bit

Overview:
Sequential accumulator that sits directly downstream of the 8-bit adder and consumes its sum and carry outputs.
- On a start command, clears its accumulator and accepts a programmed number of 8-bit samples under a valid qualifier.
- Each accepted sample is added to the running sum through an instance of adder_8bit; every carry-out from that adder is counted as a wrap-around event.
- Reports the final modulo-256 sum, the wrap count and a one-cycle completion strobe.

Parameters:
- OVF_WIDTH, 4, width of the wrap-around (carry) counter; the counter saturates at 2^OVF_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start_in  input  1  begins a new accumulation; sampled only in IDLE
- count_in  input  8  number of samples to accumulate; sampled together with start_in
- data_in  input  8  sample operand
- data_valid_in  input  1  data_in is accepted on this edge when in ACCUM
- sum_out  output  8  accumulated sum modulo 256
- ovf_count_out  output  OVF_WIDTH  number of adder carry-outs, saturating
- busy_out  output  1  high in ACCUM and DONE
- done_out  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE; sum_out=0, ovf_count_out=0, busy_out=0, done_out=0; internal remaining-count=0. Takes effect immediately, including mid-accumulation; no partial result is retained.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_in=1 with count_in!=0 -> ACCUM; clear accumulator and ovf counter to 0; load remaining=count_in.
  - start_in=1 with count_in=0 -> DONE; accumulator and ovf counter cleared to 0.
  - data_valid_in is ignored in IDLE.
  - Results of the previous run stay stable on sum_out/ovf_count_out.
- ACCUM, on each edge with data_valid_in=1:
  - acc <= adder_8bit.sum_out of (acc, data_in).
  - If adder carry_out=1 and the ovf counter is below its max, increment the counter.
  - remaining <= remaining-1.
  - If remaining==1 before the decrement, go to DONE.
  - data_valid_in=0 holds all state; there is no timeout.
- DONE: done_out=1 for exactly one cycle, then IDLE unconditionally. start_in is ignored in DONE.
- start_in is ignored while busy_out=1; no restart or abort except via rst.
- A data_valid_in that is high in the same cycle as an accepted start_in is not counted. The first sample is taken on the edge after entry to ACCUM.
- Latency: the last valid sample accepted at edge k -> done_out=1 and final sum_out/ovf_count_out visible during cycle k+1.
- sum_out is combinationally the accumulator register. It changes during ACCUM and is only guaranteed final when done_out=1 and afterwards in IDLE.
- Width rules:
  - Sum wraps modulo 256 with no saturation.
  - ovf_count_out saturates at 2^OVF_WIDTH-1 and never wraps.
  - count_in=255 is the maximum run length.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, ACCUM=2'd1, DONE=2'd2, and DATA_WIDTH=8.
- One sub-module: reuse the existing adder_8bit unmodified as the datapath adder. The accumulator is a_in, data_in is b_in, and its sum_out and carry_out feed the registers.
- No other hierarchy.

Test Plan:
1. Basic sum: start_in with count_in=3, then data 10, 20, 30 with valid -> done_out pulses one cycle after the 3rd sample; sum_out=60, ovf_count_out=0.
2. Single wrap: count_in=2, data 200, 100 -> sum_out=44, ovf_count_out=1.
3. Gaps and multiple wraps: count_in=4, data 255 four times with data_valid_in low on alternating cycles between them -> sum_out=252, ovf_count_out=3; busy_out stays high throughout the gaps.
4. Saturation: count_in=20, data 255 twenty times -> 19 carries occur; ovf_count_out=15 (saturated), sum_out=236.
5. Zero-length and ignored inputs:
   - count_in=0 -> done_out on the next cycle, sum_out=0, ovf_count_out=0.
   - data_valid_in in IDLE does not change sum_out.
   - start_in during ACCUM does not change remaining or acc.
6. Reset mid-run: count_in=5, 2 samples of 100 accepted, assert rst asynchronously between edges -> outputs go to 0 immediately and state is IDLE. A following run with count_in=1, data 7 -> sum_out=7.

Source files
------------

// File: rtl/adder_accumulator_8bit_pkg.sv
// Shared definitions for the 8-bit adder accumulator.
//   state_e    : accumulator control state encoding
//   DATA_WIDTH : sample / accumulator width
package adder_accumulator_8bit_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : adder_accumulator_8bit_pkg

// File: rtl/adder_accumulator_8bit_adder.sv
// adder_8bit: plain unsigned 8-bit adder with carry-out.
//   a_in, b_in : operands
//   sum_out    : (a_in + b_in) mod 256
//   carry_out  : carry out of bit 7
module adder_8bit
    import adder_accumulator_8bit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  carry_out
);

    logic [DATA_WIDTH:0] full_sum;

    always_comb begin
        full_sum  = {1'b0, a_in} + {1'b0, b_in};
        sum_out   = full_sum[DATA_WIDTH-1:0];
        carry_out = full_sum[DATA_WIDTH];
    end

endmodule : adder_8bit

// File: rtl/adder_accumulator_8bit.sv
// adder_accumulator_8bit: accumulates a programmed number of 8-bit samples
// through adder_8bit, counting adder carry-outs (saturating).
//   clk, rst       : clock, async active-high reset
//   start_in       : begin a run (IDLE only), with count_in = sample count
//   data_in        : sample, accepted in ACCUM when data_valid_in is high
//   sum_out        : accumulator, modulo 256
//   ovf_count_out  : saturating carry-out count
//   busy_out       : high in ACCUM and DONE
//   done_out       : one-cycle completion pulse
module adder_accumulator_8bit
    import adder_accumulator_8bit_pkg::*;
#(
    parameter int unsigned OVF_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] count_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic [OVF_WIDTH-1:0]  ovf_count_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [OVF_WIDTH-1:0] OVF_MAX = '1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
    logic [OVF_WIDTH-1:0]  ovf_q,   ovf_d;
    logic [DATA_WIDTH-1:0] rem_q,   rem_d;

    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_carry;

    // Datapath adder: accumulator plus incoming sample.
    adder_8bit u_adder (
        .a_in      (acc_q),
        .b_in      (data_in),
        .sum_out   (add_sum),
        .carry_out (add_carry)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    acc_d   = '0;
                    ovf_d   = '0;
                    rem_d   = count_in;
                    state_d = (count_in != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (data_valid_in) begin
                    acc_d = add_sum;
                    if (add_carry && (ovf_q != OVF_MAX)) begin
                        ovf_d = ovf_q + OVF_WIDTH'(1);
                    end
                    rem_d = rem_q - DATA_WIDTH'(1);
                    // Last sample of the run.
                    if (rem_q == DATA_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are direct decodes of the registered state and datapath.
    assign sum_out       = acc_q;
    assign ovf_count_out = ovf_q;
    assign busy_out      = (state_q == ACCUM) || (state_q == DONE);
    assign done_out      = (state_q == DONE);

endmodule : adder_accumulator_8bit
